// File: rtl/rgb_pkg.sv
// Shared constants and types for the RGB PWM driver: channel widths, channel
// indices and the LED-off pattern.
package rgb_pkg;

    localparam int RGB_W  = 8;
    localparam int NUM_CH = 3;

    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    // LED is active low, so all ones is dark.
    localparam logic [NUM_CH-1:0] LED_OFF = 3'b111;

    typedef enum logic {
        SHADOW_EMPTY = 1'b0,
        SHADOW_FULL  = 1'b1
    } shadow_state_e;

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Color request handshake: packed {red, green, blue} duty offered with a
// valid/ready pair; the driver side is the slave.
interface rgb_pwm_driver_if
    import rgb_pkg::*;
#(
    parameter int W = RGB_W
) ();

    logic             COLOR_VALID;
    logic             COLOR_READY;
    logic [3*W-1:0]   COLOR_DATA;

    modport master (
        output COLOR_VALID,
        output COLOR_DATA,
        input  COLOR_READY
    );

    modport slave (
        input  COLOR_VALID,
        input  COLOR_DATA,
        output COLOR_READY
    );

endinterface

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM channel: holds the active duty (gamma-corrected when the
// RGB_PWM_GAMMA_EN macro is defined) and drives a registered active-low bit.
module pwm_channel
    import rgb_pkg::*;
#(
    parameter int W = RGB_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] duty_i,
    input  logic [W-1:0] pwm_cnt_i,
    output logic         led_n_o
);

    logic [W-1:0] duty_new;
    logic [W-1:0] duty_q;
    logic [W-1:0] duty_d;
    logic         led_n_q;
    logic         led_n_d;

`ifdef RGB_PWM_GAMMA_EN
    // Square law keeps the upper half of the 2W-bit product: 255 -> 254.
    logic [2*W-1:0] duty_sq;

    always_comb begin
        duty_sq  = duty_i * duty_i;
        duty_new = duty_sq[2*W-1:W];
    end
`else
    always_comb begin
        duty_new = duty_i;
    end
`endif

    always_comb begin
        duty_d  = duty_q;
        led_n_d = ~(pwm_cnt_i < duty_q);
        if (load_i) begin
            duty_d = duty_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q  <= '0;
            led_n_q <= 1'b1;
        end else begin
            duty_q  <= duty_d;
            led_n_q <= led_n_d;
        end
    end

    assign led_n_o = led_n_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Flicker-free RGB PWM driver: duty updates land in a shadow register and are
// applied only at a period boundary. Optional gamma via RGB_PWM_GAMMA_EN.
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int W        = RGB_W,
    parameter int PRESCALE = 47
) (
    input  logic                 CLK,
    input  logic                 RST,
    rgb_pwm_driver_if.slave      color,
    output logic                 PERIOD_END,
    output logic [NUM_CH-1:0]    RGB
);

    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PW-1:0] PRESCALE_V = PW'(PRESCALE);
    localparam logic [W-1:0]  CNT_MAX    = {W{1'b1}};

    logic [PW-1:0]     presc_q;
    logic [PW-1:0]     presc_d;
    logic [W-1:0]      pwm_cnt_q;
    logic [W-1:0]      pwm_cnt_d;
    shadow_state_e     state_q;
    shadow_state_e     state_d;
    logic [3*W-1:0]    shadow_q;
    logic [3*W-1:0]    shadow_d;
    logic              period_end_q;
    logic              period_end_d;
    logic              tick;
    logic              wrap;
    logic              load;

    always_comb begin
        tick      = (presc_q == PRESCALE_V);
        wrap      = tick && (pwm_cnt_q == CNT_MAX);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end

    // A full shadow can only drain at the wrap, and an empty one only fills,
    // so a wrap-cycle accept waits a full period before it becomes active.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        load         = 1'b0;
        period_end_d = wrap;
        case (state_q)
            SHADOW_EMPTY: begin
                if (color.COLOR_VALID) begin
                    shadow_d = color.COLOR_DATA;
                    state_d  = SHADOW_FULL;
                end
            end
            SHADOW_FULL: begin
                if (wrap) begin
                    load    = 1'b1;
                    state_d = SHADOW_EMPTY;
                end
            end
            default: begin
                state_d = SHADOW_EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q      <= '0;
            pwm_cnt_q    <= '0;
            state_q      <= SHADOW_EMPTY;
            shadow_q     <= '0;
            period_end_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            pwm_cnt_q    <= pwm_cnt_d;
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            period_end_q <= period_end_d;
        end
    end

    assign color.COLOR_READY = (state_q == SHADOW_EMPTY);
    assign PERIOD_END        = period_end_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pwm_channel #(
            .W (W)
        ) u_pwm_channel (
            .clk       (CLK),
            .rst       (RST),
            .load_i    (load),
            .duty_i    (shadow_q[c*W +: W]),
            .pwm_cnt_i (pwm_cnt_q),
            .led_n_o   (RGB[c])
        );
    end

endmodule
